// File: rtl/score_display_scan.sv
// score_display_scan: converts the two player scores from binary to BCD one bit
// per clock, then time-multiplexes the digits onto a common-anode 7-segment bank.
//
// state  | meaning
// IDLE   | waiting for Load
// CONV0  | double-dabble of the latched channel 0 value, MSB first
// CONV1  | double-dabble of the latched channel 1 value, MSB first
// COMMIT | both channels' digit registers written together, Done high
module score_display_scan #(
    parameter int VALUE_WIDTH   = 8,
    parameter int DIGITS_PER_CH = 2,
    parameter int NUM_ANODES    = 8,
    parameter int SCAN_DIV_BITS = 17,
    parameter int BLINK_BIT     = 25,
    parameter int LZ_SUPPRESS   = 1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Load,
    input  logic [VALUE_WIDTH-1:0] Value0,
    input  logic [VALUE_WIDTH-1:0] Value1,
    input  logic [1:0]             Blink,
    output logic                   Busy,
    output logic                   Done,
    output logic [6:0]             out7,
    output logic [NUM_ANODES-1:0]  en_out
);

    localparam int SLOT_W   = $clog2(NUM_ANODES);
    // enough BCD nibbles for any VALUE_WIDTH-bit value (10^ceil(W/3) > 2^W)
    localparam int BCD_RAW  = (VALUE_WIDTH + 2) / 3;
    localparam int BCD_N    = (BCD_RAW > DIGITS_PER_CH) ? BCD_RAW : DIGITS_PER_CH;
    localparam int BCD_W    = 4 * BCD_N;
    localparam int DIG_W    = 4 * DIGITS_PER_CH;
    localparam int CNT_W    = (VALUE_WIDTH > 1) ? $clog2(VALUE_WIDTH) : 1;
    localparam int CH1_BASE = NUM_ANODES - DIGITS_PER_CH;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(VALUE_WIDTH - 1);
    localparam logic [63:0]      MAX_SHOWN = 64'(10 ** DIGITS_PER_CH - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV0  = 2'd1;
    localparam logic [1:0] ST_CONV1  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    logic [1:0]             state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [VALUE_WIDTH-1:0] lat0, lat1, shreg;
    logic [BCD_W-1:0]       bcd, bcd_ch0, bcd_step;
    logic [DIG_W-1:0]       dig0, dig1;
    logic [BLINK_BIT:0]     scan_cnt;
    logic [SLOT_W-1:0]      slot;
    logic [3:0]             code;
    logic                   ch_sel;
    logic                   blank;
    logic [6:0]             seg_nxt;
    logic [NUM_ANODES-1:0]  en_nxt;

    // one double-dabble step: add 3 to every nibble >= 5, then shift in one bit
    function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b, input logic in_bit);
        logic [BCD_W-1:0] t;
        t = b;
        for (int i = 0; i < BCD_N; i++) begin
            if (t[4*i +: 4] >= 4'd5)
                t[4*i +: 4] = t[4*i +: 4] + 4'd3;
        end
        return {t[BCD_W-2:0], in_bit};
    endfunction

    // displayed digit codes: dashes when over range, leading zeros blanked above the MSD
    function automatic logic [DIG_W-1:0] fmt_digits(input logic [BCD_W-1:0] b,
                                                    input logic [VALUE_WIDTH-1:0] v);
        logic [DIG_W-1:0] d;
        logic seen;
        if (64'(v) > MAX_SHOWN)
            return {DIGITS_PER_CH{4'hA}};
        d    = b[DIG_W-1:0];
        seen = 1'b0;
        if (LZ_SUPPRESS != 0) begin
            for (int k = DIGITS_PER_CH - 1; k >= 1; k--) begin
                if (d[4*k +: 4] != 4'd0)
                    seen = 1'b1;
                if (!seen)
                    d[4*k +: 4] = 4'hF;
            end
        end
        return d;
    endfunction

    // active-low segments a..g; 4'hA is a dash, everything above is blank
    function automatic logic [6:0] seg_of(input logic [3:0] c);
        case (c)
            4'd0:    seg_of = 7'b0000001;
            4'd1:    seg_of = 7'b1001111;
            4'd2:    seg_of = 7'b0010010;
            4'd3:    seg_of = 7'b0000110;
            4'd4:    seg_of = 7'b1001100;
            4'd5:    seg_of = 7'b0100100;
            4'd6:    seg_of = 7'b0100000;
            4'd7:    seg_of = 7'b0001111;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0000100;
            4'hA:    seg_of = 7'b1111110;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    assign bcd_step = dabble(bcd, shreg[VALUE_WIDTH-1]);
    assign Busy     = (state != ST_IDLE);
    assign Done     = (state == ST_COMMIT);

    // converter FSM; a Load during COMMIT is accepted so back-to-back updates lose no cycle
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            lat0    <= '0;
            lat1    <= '0;
            shreg   <= '0;
            bcd     <= '0;
            bcd_ch0 <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_COMMIT: begin
                    if (Load) begin
                        state   <= ST_CONV0;
                        lat0    <= Value0;
                        lat1    <= Value1;
                        shreg   <= Value0;
                        bcd     <= '0;
                        bit_cnt <= CNT_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CONV0: begin
                    if (bit_cnt == '0) begin
                        bcd_ch0 <= bcd_step;
                        bcd     <= '0;
                        shreg   <= lat1;
                        bit_cnt <= CNT_LOAD;
                        state   <= ST_CONV1;
                    end else begin
                        bcd     <= bcd_step;
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                ST_CONV1: begin
                    bcd   <= bcd_step;
                    shreg <= shreg << 1;
                    if (bit_cnt == '0)
                        state <= ST_COMMIT;
                    else
                        bit_cnt <= bit_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // display digit registers change only in COMMIT, so a half-converted score is never shown
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            dig0 <= '1;
            dig1 <= '1;
        end else if (state == ST_COMMIT) begin
            dig0 <= fmt_digits(bcd_ch0, lat0);
            dig1 <= fmt_digits(bcd, lat1);
        end
    end

    // free-running scan/blink counter
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            scan_cnt <= '0;
        else
            scan_cnt <= scan_cnt + 1'b1;
    end

    // slot decode: channel 0 on the low anodes, channel 1 on the top anodes, gap stays dark
    always_comb begin
        slot   = scan_cnt[SCAN_DIV_BITS +: SLOT_W];
        code   = 4'hF;
        ch_sel = 1'b0;
        for (int k = 0; k < DIGITS_PER_CH; k++) begin
            if (slot == SLOT_W'(k)) begin
                code   = dig0[4*k +: 4];
                ch_sel = 1'b0;
            end
            if (slot == SLOT_W'(CH1_BASE + k)) begin
                code   = dig1[4*k +: 4];
                ch_sel = 1'b1;
            end
        end
        blank   = (code > 4'hA) || (Blink[ch_sel] && scan_cnt[BLINK_BIT]);
        en_nxt  = blank ? '1 : ~(NUM_ANODES'(1) << slot);
        seg_nxt = blank ? 7'b1111111 : seg_of(code);
    end

    // anode and segments registered together so a new anode never shows the old digit
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            out7   <= 7'b1111111;
            en_out <= '1;
        end else begin
            out7   <= seg_nxt;
            en_out <= en_nxt;
        end
    end

endmodule

// File: tb/tb_score_display_scan.sv
// Bench for score_display_scan: directed handshake/reset steps plus randomized
// scores and blink settings, checked against a decimal reference model.
`timescale 1ns/1ps
module tb_score_display_scan;

    localparam int VW  = 8;
    localparam int DPC = 2;
    localparam int NA  = 8;
    localparam int SDB = 2;
    localparam int BB  = 6;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          Load = 1'b0;
    logic [VW-1:0] Value0 = '0;
    logic [VW-1:0] Value1 = '0;
    logic [1:0]    Blink = 2'b00;
    logic          Busy, Done;
    logic [6:0]    out7;
    logic [NA-1:0] en_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int edges  = 0;
    int mv [2] = '{0, 0};
    bit mvalid = 1'b0;

    logic [6:0] seg_tab [0:10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                   7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                   7'b0000000, 7'b0000100, 7'b1111110};

    score_display_scan #(
        .VALUE_WIDTH(VW), .DIGITS_PER_CH(DPC), .NUM_ANODES(NA),
        .SCAN_DIV_BITS(SDB), .BLINK_BIT(BB), .LZ_SUPPRESS(1)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Load(Load), .Value0(Value0), .Value1(Value1),
        .Blink(Blink), .Busy(Busy), .Done(Done), .out7(out7), .en_out(en_out)
    );

    always #5 Clk = ~Clk;

    // clocks seen since reset release
    always @(posedge Clk or posedge Rst) begin
        if (Rst) edges <= 0;
        else     edges <= edges + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // digit k of channel value v as displayed: -1 blank, 10 dash, else 0..9
    function automatic int shown_digit(input int v, input int k);
        if (!mvalid) return -1;
        if (v > 10 ** DPC - 1) return 10;
        if (k > 0 && v < 10 ** k) return -1;
        return (v / (10 ** k)) % 10;
    endfunction

    task automatic expect_scan(output logic [7:0] en, output logic [6:0] seg);
        int ph, slot, ch, k, d;
        en  = 8'hFF;
        seg = 7'b1111111;
        if (edges == 0) return;
        ph   = (edges - 1) % (1 << (BB + 1));
        slot = (ph >> SDB) % NA;
        if (slot < DPC) begin
            ch = 0; k = slot;
        end else if (slot >= NA - DPC) begin
            ch = 1; k = slot - (NA - DPC);
        end else return;
        if (Blink[ch] && ph >= (1 << BB)) return;
        d = shown_digit(mv[ch], k);
        if (d < 0) return;
        en  = ~(8'd1 << slot);
        seg = seg_tab[d];
    endtask

    task automatic scan_check(input int cycles);
        logic [7:0] e_en;
        logic [6:0] e_seg;
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            expect_scan(e_en, e_seg);
            chk("en_out", en_out, e_en);
            chk("out7", out7, e_seg);
        end
    endtask

    // call at a negedge; returns at the negedge one cycle after the load edge
    task automatic start_load(input int v0, input int v1);
        Load   = 1'b1;
        Value0 = VW'(v0);
        Value1 = VW'(v1);
        @(negedge Clk);
        Load = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (Done !== 1'b1 && n < 40) begin
            chk("busy_during_conv", Busy, 1);
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic convert(input int v0, input int v1);
        int n;
        start_load(v0, v1);
        wait_done(n);
        chk("done_latency", n, 2 * VW + 1);
        chk("busy_with_done", Busy, 1);
        @(negedge Clk);
        chk("done_width", Done, 0);
        chk("busy_release", Busy, 0);
        mv[0] = v0; mv[1] = v1; mvalid = 1'b1;
    endtask

    task automatic find_anode(input string tag, input int a, input logic [6:0] seg);
        int n;
        n = 0;
        while (en_out !== ~(8'd1 << a) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "_found"}, 32'(n < 200), 1);
        chk(tag, out7, seg);
    endtask

    initial begin
        int n, dcount, v0, v1;

        // reset state and idle scan
        @(negedge Clk);
        chk("rst_en_out", en_out, 8'hFF);
        chk("rst_out7", out7, 7'b1111111);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        @(negedge Clk);
        Rst = 1'b0;
        scan_check(32);
        chk("idle_busy", Busy, 0);

        // 42 / 7
        convert(42, 7);
        scan_check(128);
        find_anode("a0_is_2", 0, 7'b0010010);
        find_anode("a1_is_4", 1, 7'b1001100);
        find_anode("a6_is_7", 6, 7'b0001111);

        // over-range and zero
        convert(100, 0);
        scan_check(128);
        find_anode("a0_dash", 0, 7'b1111110);
        find_anode("a1_dash", 1, 7'b1111110);
        find_anode("a6_zero", 6, 7'b0000001);

        // Load while busy is dropped
        start_load(42, 7);
        n = 1;
        repeat (2) begin @(negedge Clk); n++; end
        Load = 1'b1; Value0 = 8'd9; Value1 = 8'd9;
        @(negedge Clk);
        Load = 1'b0; n++;
        while (Done !== 1'b1 && n < 40) begin @(negedge Clk); n++; end
        chk("ignored_load_latency", n, 2 * VW + 1);
        mv[0] = 42; mv[1] = 7; mvalid = 1'b1;
        dcount = 0;
        repeat (30) begin
            @(negedge Clk);
            if (Done === 1'b1) dcount++;
        end
        chk("ignored_load_no_2nd_done", dcount, 0);
        chk("ignored_load_idle", Busy, 0);
        scan_check(128);

        // Load coincident with Done is accepted
        start_load(13, 250);
        wait_done(n);
        chk("chain_latency1", n, 2 * VW + 1);
        start_load(5, 68);
        chk("chain_busy_held", Busy, 1);
        chk("chain_done_low", Done, 0);
        wait_done(n);
        chk("chain_latency2", n, 2 * VW + 1);
        @(negedge Clk);
        chk("chain_busy_release", Busy, 0);
        mv[0] = 5; mv[1] = 68;
        scan_check(128);

        // blink per channel
        Blink = 2'b10;
        scan_check(256);
        Blink = 2'b01;
        scan_check(256);
        Blink = 2'b00;

        // reset mid-conversion
        start_load(77, 33);
        repeat (4) @(negedge Clk);
        Rst = 1'b1;
        #1;
        chk("midrst_busy", Busy, 0);
        chk("midrst_done", Done, 0);
        chk("midrst_en_out", en_out, 8'hFF);
        chk("midrst_out7", out7, 7'b1111111);
        mvalid = 1'b0;
        dcount = 0;
        repeat (3) begin
            @(negedge Clk);
            if (Done === 1'b1) dcount++;
        end
        chk("midrst_no_done", dcount, 0);
        Rst = 1'b0;
        scan_check(40);
        convert(61, 5);
        scan_check(128);

        // boundaries
        convert(99, 10);
        scan_check(128);
        convert(9, 255);
        scan_check(128);

        // randomized scores and blink
        for (int it = 0; it < 10; it++) begin
            v0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 255)) : int'($urandom_range(0, 99));
            v1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 255)) : int'($urandom_range(0, 99));
            Blink = 2'($urandom_range(0, 3));
            convert(v0, v1);
            scan_check(136);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
